link_stack: RTL and testbench

Parametrised multi-entry return-address (link) stack. It replaces the single-entry Stack register in the A09 CPU datapath. A JPL instruction pushes the call address + WordSize; RET pops, and Top feeds the MUX_PC return-address input. It adds configurable depth, full/empty status, a selectable overflow policy, tail-call replace, flush, and sticky error flags.

---
 rtl/link_stack.sv | 121 ++++++++++++
 tb/tb_link_stack.sv | 124 ++++++++++++
 2 files changed

// File: rtl/link_stack.sv
// link_stack: multi-entry return-address stack with overflow policy, tail-call replace, flush and sticky error flags
//
// Ports:
//   Clk        rising-edge clock
//   Reset      synchronous, active-low reset
//   Push       push LinkAddr + WordSize this cycle
//   Pop        pop the top entry this cycle
//   Flush      discard all entries
//   ErrClr     clear the Overflow/Underflow sticky flags
//   LinkAddr   address of the calling instruction
//   Top        current top-of-stack, 0 when empty
//   Count      number of valid entries, 0..Depth
//   Empty      Count == 0
//   Full       Count == Depth
//   Overflow   sticky: a push arrived while full
//   Underflow  sticky: a pop arrived while empty
module link_stack #(
    parameter int DataWidth    = 8,
    parameter int Depth        = 4,
    parameter int WordSize     = 1,
    parameter int OverflowMode = 0,
    parameter int CountWidth   = $clog2(Depth + 1)
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  Push,
    input  logic                  Pop,
    input  logic                  Flush,
    input  logic                  ErrClr,
    input  logic [DataWidth-1:0]  LinkAddr,
    output logic [DataWidth-1:0]  Top,
    output logic [CountWidth-1:0] Count,
    output logic                  Empty,
    output logic                  Full,
    output logic                  Overflow,
    output logic                  Underflow
);
    localparam int                    PtrWidth  = $clog2(Depth);
    localparam logic [PtrWidth-1:0]   LastIdx   = PtrWidth'(Depth - 1);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [DataWidth-1:0]  mem_q [Depth];
    logic [DataWidth-1:0]  mem_d [Depth];
    logic [PtrWidth-1:0]   ptr_q, ptr_d, ptr_inc, ptr_dec, waddr;
    logic [CountWidth-1:0] count_q, count_d;
    logic                  ovf_q, ovf_d, unf_q, unf_d;
    logic                  ovf_set, unf_set, we, is_empty, is_full;
    logic [DataWidth-1:0]  push_val;

    // ptr_q indexes the current top entry; storage is a circular buffer so
    // overwriting the oldest entry on a full push is just another increment.
    always_comb begin
        is_empty = count_q == '0;
        is_full  = count_q == FullCount;
        ptr_inc  = ptr_q == LastIdx ? '0 : ptr_q + 1'b1;
        ptr_dec  = ptr_q == '0 ? LastIdx : ptr_q - 1'b1;
        push_val = LinkAddr + DataWidth'(WordSize);
        ptr_d    = ptr_q;
        count_d  = count_q;
        we       = 1'b0;
        waddr    = ptr_inc;
        ovf_set  = 1'b0;
        unf_set  = 1'b0;
        if (Flush) begin
            count_d = '0;
        end else if (Push && Pop) begin
            // tail-call: replace the top in place; on empty it degrades to a push
            we      = 1'b1;
            unf_set = is_empty;
            if (is_empty) begin
                ptr_d   = ptr_inc;
                count_d = CountWidth'(1);
            end else begin
                waddr = ptr_q;
            end
        end else if (Push) begin
            ovf_set = is_full;
            if (!is_full || OverflowMode != 0) begin
                we    = 1'b1;
                ptr_d = ptr_inc;
                if (!is_full) count_d = count_q + 1'b1;
            end
        end else if (Pop) begin
            unf_set = is_empty;
            if (!is_empty) begin
                ptr_d   = ptr_dec;
                count_d = count_q - 1'b1;
            end
        end
        ovf_d = Flush ? ovf_q : (ovf_set | (ovf_q & ~ErrClr));
        unf_d = Flush ? unf_q : (unf_set | (unf_q & ~ErrClr));
        mem_d = mem_q;
        if (we) mem_d[waddr] = push_val;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            ptr_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // storage needs no reset: Top is masked to zero whenever the stack is empty
    always_ff @(posedge Clk) begin
        if (Reset) mem_q <= mem_d;
    end

    assign Top       = is_empty ? '0 : mem_q[ptr_q];
    assign Count     = count_q;
    assign Empty     = is_empty;
    assign Full      = is_full;
    assign Overflow  = ovf_q;
    assign Underflow = unf_q;
endmodule

// File: tb/tb_link_stack.sv
// tb_link_stack: directed bench for link_stack, reject (u0) and overwrite (u1) overflow policies side by side
module tb_link_stack;
    logic       Clk = 1'b0;
    logic       Reset = 1'b0;
    logic       Push = 1'b0, Pop = 1'b0, Flush = 1'b0, ErrClr = 1'b0;
    logic [7:0] LinkAddr = 8'h00;
    logic [7:0] top0, top1;
    logic [2:0] cnt0, cnt1;
    logic       emp0, emp1, ful0, ful1, ovf0, ovf1, unf0, unf1;
    int         errors = 0;
    int         checks = 0;

    always #5 Clk = ~Clk;

    link_stack #(.OverflowMode(0)) u0 (
        .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .Flush(Flush), .ErrClr(ErrClr),
        .LinkAddr(LinkAddr), .Top(top0), .Count(cnt0), .Empty(emp0), .Full(ful0),
        .Overflow(ovf0), .Underflow(unf0)
    );

    link_stack #(.OverflowMode(1)) u1 (
        .Clk(Clk), .Reset(Reset), .Push(Push), .Pop(Pop), .Flush(Flush), .ErrClr(ErrClr),
        .LinkAddr(LinkAddr), .Top(top1), .Count(cnt1), .Empty(emp1), .Full(ful1),
        .Overflow(ovf1), .Underflow(unf1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic state(input string tag, input int inst, input logic [7:0] t, input logic [2:0] c,
                         input logic e, input logic f, input logic o, input logic u);
        string p;
        p = $sformatf("%s/u%0d", tag, inst);
        chk({p, ".top"}, inst == 0 ? top0 : top1, t);
        chk({p, ".count"}, inst == 0 ? cnt0 : cnt1, c);
        chk({p, ".empty"}, inst == 0 ? emp0 : emp1, e);
        chk({p, ".full"}, inst == 0 ? ful0 : ful1, f);
        chk({p, ".ovf"}, inst == 0 ? ovf0 : ovf1, o);
        chk({p, ".unf"}, inst == 0 ? unf0 : unf1, u);
    endtask

    task automatic both(input string tag, input logic [7:0] t, input logic [2:0] c,
                        input logic e, input logic f, input logic o, input logic u);
        state(tag, 0, t, c, e, f, o, u);
        state(tag, 1, t, c, e, f, o, u);
    endtask

    task automatic step(input logic rst_n, input logic psh, input logic pp, input logic fl,
                        input logic ec, input logic [7:0] a);
        Reset = rst_n; Push = psh; Pop = pp; Flush = fl; ErrClr = ec; LinkAddr = a;
        @(posedge Clk);
        #1;
        Push = 1'b0; Pop = 1'b0; Flush = 1'b0; ErrClr = 1'b0;
    endtask

    initial begin
        // 1: reset, with Pop held during reset
        step(0, 0, 1, 0, 0, 8'h00);
        step(0, 0, 1, 0, 0, 8'h00);
        both("reset", 8'h00, 3'd0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 8'h00);
        both("idle", 8'h00, 3'd0, 1, 0, 0, 0);

        // 2: basic push/pop
        step(1, 1, 0, 0, 0, 8'h10); both("push10", 8'h11, 3'd1, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 8'h20); both("push20", 8'h21, 3'd2, 0, 0, 0, 0);
        step(1, 1, 0, 0, 0, 8'h30); both("push30", 8'h31, 3'd3, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 8'h77); both("hold", 8'h31, 3'd3, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00); both("pop1", 8'h21, 3'd2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00); both("pop2", 8'h11, 3'd1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00); both("pop3", 8'h00, 3'd0, 1, 0, 0, 0);

        // 3/4: fill, overflow under both policies
        step(1, 1, 0, 0, 0, 8'h01);
        step(1, 1, 0, 0, 0, 8'h02);
        step(1, 1, 0, 0, 0, 8'h03);
        step(1, 1, 0, 0, 0, 8'h04); both("fill", 8'h05, 3'd4, 0, 1, 0, 0);
        step(1, 1, 0, 0, 0, 8'h50);
        state("ovf", 0, 8'h05, 3'd4, 0, 1, 1, 0);
        state("ovf", 1, 8'h51, 3'd4, 0, 1, 1, 0);
        step(1, 0, 0, 0, 1, 8'h00);
        state("errclr", 0, 8'h05, 3'd4, 0, 1, 0, 0);
        state("errclr", 1, 8'h51, 3'd4, 0, 1, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00);
        state("opop1", 0, 8'h04, 3'd3, 0, 0, 0, 0);
        state("opop1", 1, 8'h05, 3'd3, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00);
        state("opop2", 0, 8'h03, 3'd2, 0, 0, 0, 0);
        state("opop2", 1, 8'h04, 3'd2, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00);
        state("opop3", 0, 8'h02, 3'd1, 0, 0, 0, 0);
        state("opop3", 1, 8'h03, 3'd1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00); both("opop4", 8'h00, 3'd0, 1, 0, 0, 0);

        // 5: address wrap, tail-call replace, push+pop on empty
        step(1, 1, 0, 0, 0, 8'hFF); both("wrap", 8'h00, 3'd1, 0, 0, 0, 0);
        step(1, 1, 1, 0, 0, 8'h40); both("replace", 8'h41, 3'd1, 0, 0, 0, 0);
        step(1, 0, 1, 0, 0, 8'h00); both("drain", 8'h00, 3'd0, 1, 0, 0, 0);
        step(1, 1, 1, 0, 0, 8'h40); both("pp_empty", 8'h41, 3'd1, 0, 0, 0, 1);

        // replace while full must not overflow
        step(1, 1, 0, 0, 0, 8'h60);
        step(1, 1, 0, 0, 0, 8'h70);
        step(1, 1, 0, 0, 0, 8'h80); both("refill", 8'h81, 3'd4, 0, 1, 0, 1);
        step(1, 1, 1, 0, 0, 8'h90); both("replace_full", 8'h91, 3'd4, 0, 1, 0, 1);
        step(1, 0, 1, 0, 0, 8'h00); both("under_replace", 8'h71, 3'd3, 0, 0, 0, 1);

        // 6: flush beats push, flags hold; reset mid-sequence; set beats ErrClr
        step(1, 1, 0, 1, 0, 8'h55); both("flush", 8'h00, 3'd0, 1, 0, 0, 1);
        step(1, 0, 0, 0, 1, 8'h00); both("clr_unf", 8'h00, 3'd0, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0, 8'hA0);
        step(1, 1, 0, 0, 0, 8'hB0); both("push2", 8'hB1, 3'd2, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0, 8'hC0); both("mid_reset", 8'h00, 3'd0, 1, 0, 0, 0);
        step(1, 0, 1, 0, 1, 8'h00); both("set_wins", 8'h00, 3'd0, 1, 0, 0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
